run_sequencer: RTL
==================

// Module: run_sequencer
// PURPOSE
//  Batch controller directly upstream of the asynchronous-update datapath. Accepts one command (run count, base seed,
//  inhibitor mask, timeout), then per run: resets the datapath, loads inhibitor bits, starts the run, waits for
//  steady_state or timeout, and emits one result record (final state, iteration count, run index, timeout flag).
// PARAMETERS
//  RULES      64  network width; matches datapath `RULES
//  LOG_RULES  6   clog2(RULES); width of inhibitor select
//  LOG_ITER   16  width of datapath iteration_number
//  TO_W       24  width of timeout cycle counter
// PORTS
//  clk              in   1          clock
//  rst              in   1          asynchronous, active-high reset
//  cmd_valid        in   1          command offered
//  cmd_ready        out  1          command accepted when valid&ready
//  cmd_runs         in   16         number of runs in batch
//  cmd_seed         in   64         seed of run 0
//  cmd_inhib        in   RULES      1 = force rule i off for whole batch
//  cmd_timeout      in   TO_W       max WAIT cycles per run
//  abort            in   1          cancel batch
//  dp_rst           out  1          datapath reset
//  dp_start         out  1          datapath start (level)
//  dp_ld_inhibitor  out  1          datapath inhibitor load strobe
//  dp_sel_inhibitor out  LOG_RULES  inhibitor bit index
//  dp_seed          out  64         datapath seed
//  dp_state         in   RULES      datapath network_state
//  dp_steady        in   1          datapath steady_state
//  dp_iter          in   LOG_ITER   datapath iteration_number
//  res_valid        out  1          result record valid
//  res_ready        in   1          consumer accepts on valid&ready
//  res_state        out  RULES      captured network state
//  res_iter         out  LOG_ITER   captured iteration number
//  res_run          out  16         run index 0..cmd_runs-1
//  res_timeout      out  1          1 = run ended by timeout
//  busy             out  1          high in any state but IDLE
//  done             out  1          one-cycle pulse at batch end
// BEHAVIOUR
//  Reset: FSM=IDLE; cmd_ready=1, every other output 0; command regs, counters and result regs 0.
//  FSM: IDLE -> RST_DP -> INHIBIT -> WAIT -> EMIT -> (RST_DP | DONE) -> IDLE.
//  IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* and clear run_idx. cmd_runs=0 -> DONE, no record emitted.
//  RST_DP: exactly 2 cycles, dp_rst=1; dp_seed = cmd_seed + run_idx (64-bit, wraps mod 2^64), stable until the next RST_DP.
//  INHIBIT: exactly RULES cycles, index i=0..RULES-1. dp_sel_inhibitor=i every cycle.
//   dp_ld_inhibitor=cmd_inhib[i]. Fixed latency whatever the mask.
//  WAIT: dp_start=1 for the whole state. Timeout counter starts at 0 on entry and increments each cycle.
//   If dp_steady=1, capture dp_state/dp_iter, res_timeout=0, go to EMIT.
//   Else if counter==cmd_timeout, capture dp_state/dp_iter, res_timeout=1, go to EMIT.
//   dp_steady and timeout in the same cycle: steady wins. cmd_timeout=0 allows a 1-cycle WAIT.
//  EMIT: dp_start=0; res_valid=1 with res_* stable until res_ready=1. Then, if run_idx==cmd_runs-1, go to DONE; else run_idx++ and go to RST_DP.
//  DONE: done=1 for 1 cycle, then IDLE. busy=0 only in IDLE.
//  abort (any non-IDLE state): next cycle dp_start=0, res_valid=0; any pending record is dropped.
//   Then 2-cycle RST_DP with dp_rst=1, then IDLE with no done pulse. abort in IDLE is ignored.
//  Asynchronous rst mid-batch: immediate return to reset values; the latched command is lost.
//  cmd_* are sampled only on the valid&ready cycle; changes during a batch have no effect.
//  run_idx and cmd_runs are both 16 bits; cmd_runs=65535 is legal, with indices 0..65534.
// TESTING
//  1. cmd_runs=1, seed=5, inhib=0, timeout=1000; dp_steady rises 40 cycles into WAIT with dp_iter=37 ->
//     one record: res_run=0, res_iter=37, res_timeout=0; then done pulse; dp_ld_inhibitor never high.
//  2. inhib=64'h8000_0000_0000_0005 -> exactly 3 dp_ld_inhibitor strobes, with sel=0, 2, 63 in INHIBIT cycles 0, 2, 63.
//  3. cmd_runs=3, seed=64'hFFFF_FFFF_FFFF_FFFF -> dp_seed = FFFF..FF, then 0, then 1; res_run = 0, 1, 2; single done pulse.
//  4. timeout=10, dp_steady never rises -> after 11 WAIT cycles, record with res_timeout=1.
//     Second case: dp_steady rises exactly when counter==10 -> res_timeout=0.
//  5. res_ready held low for 50 cycles in EMIT -> res_* unchanged, no new RST_DP;
//     release res_ready -> next run's RST_DP follows on the next cycle.
//  6. abort during WAIT of run 1 of 4 -> dp_rst=1 for 2 cycles, return to IDLE, no done pulse, no further records.
//     cmd_runs=0 -> done pulse, no records.

Source files
------------

// File: rtl/run_sequencer.sv
// Batch controller for the asynchronous-update datapath: per run it resets the datapath, loads the inhibitor
// mask, runs to steady state or timeout and emits one result record, stalling in EMIT while res_ready is low.
module run_sequencer #(
    parameter int RULES     = 64,
    parameter int LOG_RULES = 6,
    parameter int LOG_ITER  = 16,
    parameter int TO_W      = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [15:0]          cmd_runs,
    input  logic [63:0]          cmd_seed,
    input  logic [RULES-1:0]     cmd_inhib,
    input  logic [TO_W-1:0]      cmd_timeout,
    input  logic                 abort,
    output logic                 dp_rst,
    output logic                 dp_start,
    output logic                 dp_ld_inhibitor,
    output logic [LOG_RULES-1:0] dp_sel_inhibitor,
    output logic [63:0]          dp_seed,
    input  logic [RULES-1:0]     dp_state,
    input  logic                 dp_steady,
    input  logic [LOG_ITER-1:0]  dp_iter,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RULES-1:0]     res_state,
    output logic [LOG_ITER-1:0]  res_iter,
    output logic [15:0]          res_run,
    output logic                 res_timeout,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_DP, S_INHIBIT, S_WAIT, S_EMIT, S_DONE, S_ABORT
    } state_t;

    localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] LAST_INH = TO_W'(RULES - 1);

    state_t               state_q, state_d;
    logic [15:0]          runs_q, runs_d;
    logic [RULES-1:0]     inhib_q, inhib_d;
    logic [TO_W-1:0]      timeout_q, timeout_d;
    logic [15:0]          run_idx_q, run_idx_d;
    logic [TO_W-1:0]      cnt_q, cnt_d;
    logic [63:0]          dp_seed_q, dp_seed_d;
    logic [RULES-1:0]     res_state_q, res_state_d;
    logic [LOG_ITER-1:0]  res_iter_q, res_iter_d;
    logic                 res_timeout_q, res_timeout_d;

    // One counter serves the RST_DP/ABORT length, the INHIBIT index and the WAIT timeout.
    always_comb begin
        state_d       = state_q;
        runs_d        = runs_q;
        inhib_d       = inhib_q;
        timeout_d     = timeout_q;
        run_idx_d     = run_idx_q;
        cnt_d         = cnt_q;
        dp_seed_d     = dp_seed_q;
        res_state_d   = res_state_q;
        res_iter_d    = res_iter_q;
        res_timeout_d = res_timeout_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    runs_d    = cmd_runs;
                    inhib_d   = cmd_inhib;
                    timeout_d = cmd_timeout;
                    run_idx_d = '0;
                    cnt_d     = '0;
                    if (cmd_runs == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_RST_DP;
                        dp_seed_d = cmd_seed;
                    end
                end
            end
            S_RST_DP: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_INHIBIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == LAST_INH) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT: begin
                if (dp_steady || (cnt_q == timeout_q)) begin
                    state_d       = S_EMIT;
                    res_state_d   = dp_state;
                    res_iter_d    = dp_iter;
                    res_timeout_d = !dp_steady;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_EMIT: begin
                if (res_ready) begin
                    if (run_idx_q == runs_q - 16'd1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_RST_DP;
                        run_idx_d = run_idx_q + 16'd1;
                        dp_seed_d = dp_seed_q + 64'd1;
                        cnt_d     = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ABORT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any progress made this cycle, including a record handshake.
        if (abort && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
            state_d   = S_ABORT;
            cnt_d     = '0;
            run_idx_d = run_idx_q;
            dp_seed_d = dp_seed_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            runs_q        <= '0;
            inhib_q       <= '0;
            timeout_q     <= '0;
            run_idx_q     <= '0;
            cnt_q         <= '0;
            dp_seed_q     <= '0;
            res_state_q   <= '0;
            res_iter_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            runs_q        <= runs_d;
            inhib_q       <= inhib_d;
            timeout_q     <= timeout_d;
            run_idx_q     <= run_idx_d;
            cnt_q         <= cnt_d;
            dp_seed_q     <= dp_seed_d;
            res_state_q   <= res_state_d;
            res_iter_q    <= res_iter_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign cmd_ready        = (state_q == S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign dp_rst           = (state_q == S_RST_DP) || (state_q == S_ABORT);
    assign dp_start         = (state_q == S_WAIT);
    assign dp_sel_inhibitor = (state_q == S_INHIBIT) ? cnt_q[LOG_RULES-1:0] : '0;
    assign dp_ld_inhibitor  = (state_q == S_INHIBIT) && inhib_q[cnt_q[LOG_RULES-1:0]];
    assign dp_seed          = dp_seed_q;
    assign res_valid        = (state_q == S_EMIT);
    assign res_state        = res_state_q;
    assign res_iter         = res_iter_q;
    assign res_run          = run_idx_q;
    assign res_timeout      = res_timeout_q;

endmodule
